// File: rtl/wb_stage_ls.sv
// wb_stage_ls: registered writeback stage with sub-word load extraction,
// sign/zero extension, a valid/ready memory handshake, stall output and
// a load timeout.
// Optional statistics counters are enabled by defining WB_STATS_EN.
module wb_stage_ls #(
  parameter int N       = 32,
  parameter int DEST_W  = 4,
  parameter int OFF_W   = $clog2(N/8),
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      alu_res,
  input  logic              mem_r_en,
  input  logic              wb_en,
  input  logic [DEST_W-1:0] wb_dest,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [N-1:0]      mem_rdata,
  input  logic              mem_rvalid,
  output logic              stall,
  output logic              wb_en_out,
  output logic [DEST_W-1:0] wb_dest_out,
  output logic [N-1:0]      wb_value_out,
  output logic              ld_err
`ifdef WB_STATS_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  timeout_cnt
`endif
);

  // The timeout counter only has to count up to TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  state_t              state, state_nxt;
  logic                accept, load_done, expire;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                cap_wb_en;
  logic [DEST_W-1:0]   cap_dest;
  logic [1:0]          cap_size;
  logic                cap_signed;
  logic [OFF_W-1:0]    cap_off;
  logic [OFF_W-1:0]    lane_off;
  logic [N-1:0]        shifted, mask, ld_value;
  logic                sign_bit;

  assign in_ready = (state == IDLE);
  assign stall    = (state == WAIT_MEM);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and the accept / load-complete / timeout events.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_done = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (mem_r_en) state_nxt = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane selection and extension; sub-word offsets are forced aligned.
  always_comb begin
    lane_off = '0;
    mask     = '1;
    sign_bit = 1'b0;
    case (cap_size)
      2'b00: lane_off = cap_off;
      2'b01: lane_off = cap_off & ~OFF_W'(1);
      2'b10: lane_off = cap_off & ~OFF_W'(3);
      default: lane_off = '0;
    endcase
    shifted = mem_rdata >> {lane_off, 3'b000};
    case (cap_size)
      2'b00: begin mask = N'(8'hFF);         sign_bit = shifted[7];  end
      2'b01: begin mask = N'(16'hFFFF);      sign_bit = shifted[15]; end
      2'b10: begin mask = N'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin mask = '1;              sign_bit = 1'b0;        end
    endcase
    ld_value = (shifted & mask) | ((cap_signed && sign_bit) ? ~mask : '0);
  end

  // Capture load attributes at accept and run the timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_wb_en  <= 1'b0;
      cap_dest   <= '0;
      cap_size   <= '0;
      cap_signed <= 1'b0;
      cap_off    <= '0;
      tmo_cnt    <= '0;
    end else begin
      if (accept && mem_r_en) begin
        cap_wb_en  <= wb_en;
        cap_dest   <= wb_dest;
        cap_size   <= ld_size;
        cap_signed <= ld_signed;
        cap_off    <= byte_off;
        tmo_cnt    <= '0;
      end else if (state == WAIT_MEM && !mem_rvalid && !expire) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Registered writeback strobe, destination, value and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      wb_dest_out  <= '0;
      wb_value_out <= '0;
      ld_err       <= 1'b0;
    end else begin
      ld_err <= expire;
      if (accept && !mem_r_en) begin
        wb_en_out    <= wb_en;
        wb_dest_out  <= wb_dest;
        wb_value_out <= alu_res;
      end else if (load_done) begin
        wb_en_out    <= cap_wb_en;
        wb_dest_out  <= cap_dest;
        wb_value_out <= ld_value;
      end else begin
        wb_en_out <= 1'b0;
      end
    end
  end

`ifdef WB_STATS_EN
  // Saturating retirement, load and timeout statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt  <= '0;
      load_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (((accept && !mem_r_en) || load_done || expire) && (retire_cnt != '1))
        retire_cnt <= retire_cnt + 1'b1;
      if (load_done && (load_cnt != '1))
        load_cnt <= load_cnt + 1'b1;
      if (expire && (timeout_cnt != '1))
        timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_ls.sv
// tb_wb_stage_ls: directed self-checking bench for wb_stage_ls
// (N=32, TIMEOUT=4, CNT_W=2). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_wb_stage_ls;

  localparam int N = 32;
  localparam int DEST_W = 4;
  localparam int OFF_W = 2;
  localparam int CNT_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      alu_res = '0;
  logic              mem_r_en = 1'b0;
  logic              wb_en = 1'b0;
  logic [DEST_W-1:0] wb_dest = '0;
  logic [1:0]        ld_size = '0;
  logic              ld_signed = 1'b0;
  logic [OFF_W-1:0]  byte_off = '0;
  logic [N-1:0]      mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic              stall;
  logic              wb_en_out;
  logic [DEST_W-1:0] wb_dest_out;
  logic [N-1:0]      wb_value_out;
  logic              ld_err;
`ifdef WB_STATS_EN
  logic [CNT_W-1:0]  retire_cnt, load_cnt, timeout_cnt;
`endif

  int checks = 0;
  int failures = 0;

  wb_stage_ls #(.N(N), .DEST_W(DEST_W), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .mem_r_en(mem_r_en), .wb_en(wb_en), .wb_dest(wb_dest),
    .ld_size(ld_size), .ld_signed(ld_signed), .byte_off(byte_off),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .stall(stall),
    .wb_en_out(wb_en_out), .wb_dest_out(wb_dest_out),
    .wb_value_out(wb_value_out), .ld_err(ld_err)
`ifdef WB_STATS_EN
    , .retire_cnt(retire_cnt), .load_cnt(load_cnt), .timeout_cnt(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic issue_load(input logic [1:0] size, input logic sgn,
                            input logic [OFF_W-1:0] off, input logic [DEST_W-1:0] dest);
    in_valid  = 1'b1;
    mem_r_en  = 1'b1;
    wb_en     = 1'b1;
    wb_dest   = dest;
    ld_size   = size;
    ld_signed = sgn;
    byte_off  = off;
    @(negedge clk);
    in_valid = 1'b0;
    mem_r_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wb_en_out !== 1'b0 || wb_dest_out !== '0 || wb_value_out !== '0 ||
        ld_err !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_state: en=%b dest=%0d val=%h err=%b stall=%b rdy=%b, want 0 0 0 0 0 1",
               wb_en_out, wb_dest_out, wb_value_out, ld_err, stall, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    in_valid = 1'b1; mem_r_en = 1'b0; alu_res = 32'h1234_5678; wb_en = 1'b1; wb_dest = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wb_en_out !== 1'b1 || wb_dest_out !== 4'd5 || wb_value_out !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL alu_wb: en=%b dest=%0d val=%h, want 1 5 12345678",
               wb_en_out, wb_dest_out, wb_value_out);
    end
    @(negedge clk);
    checks++;
    if (wb_en_out !== 1'b0 || wb_value_out !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL alu_pulse_end: en=%b val=%h, want 0 12345678", wb_en_out, wb_value_out);
    end
  endtask

  task automatic test_byte_load();
    int stall_cycles = 0;
    issue_load(2'b00, 1'b1, 2'd2, 4'd3);
    for (int i = 0; i < 3; i++) begin
      if (stall === 1'b1 && in_ready === 1'b0 && wb_en_out === 1'b0) stall_cycles++;
      if (i == 2) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0080_0000;
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    checks++;
    if (stall_cycles !== 3) begin
      failures++;
      $display("[TB] FAIL byte_stall: stall cycles=%0d, want 3", stall_cycles);
    end
    checks++;
    if (wb_en_out !== 1'b1 || wb_dest_out !== 4'd3 || wb_value_out !== 32'hFFFF_FF80 ||
        stall !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL byte_load: en=%b dest=%0d val=%h stall=%b rdy=%b, want 1 3 ffffff80 0 1",
               wb_en_out, wb_dest_out, wb_value_out, stall, in_ready);
    end
  endtask

  task automatic test_extract();
    logic [1:0]       sz  [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
    logic             sg  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [OFF_W-1:0] off [5] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd1};
    logic [N-1:0]     rd  [5] = '{32'hABCD_1234, 32'hABCD_1234, 32'h0000_F100,
                                  32'h8765_4321, 32'h8000_00FF};
    logic [N-1:0]     exp [5] = '{32'h0000_ABCD, 32'hFFFF_ABCD, 32'h0000_00F1,
                                  32'h8765_4321, 32'h8000_00FF};
    for (int i = 0; i < 5; i++) begin
      issue_load(sz[i], sg[i], off[i], 4'(i + 8));
      mem_rvalid = 1'b1;
      mem_rdata  = rd[i];
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++;
      if (wb_en_out !== 1'b1 || wb_dest_out !== 4'(i + 8) || wb_value_out !== exp[i]) begin
        failures++;
        $display("[TB] FAIL extract_%0d: en=%b dest=%0d val=%h, want 1 %0d %h",
                 i, wb_en_out, wb_dest_out, wb_value_out, i + 8, exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int err_early = 0;
    issue_load(2'b10, 1'b0, 2'd0, 4'd7);
    for (int i = 0; i < 4; i++) begin
      if (ld_err !== 1'b0 || stall !== 1'b1) err_early++;
      @(negedge clk);
    end
    checks++;
    if (err_early !== 0) begin
      failures++;
      $display("[TB] FAIL timeout_wait: bad cycles=%0d, want 0", err_early);
    end
    checks++;
    if (ld_err !== 1'b1 || wb_en_out !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_err: err=%b en=%b rdy=%b, want 1 0 1", ld_err, wb_en_out, in_ready);
    end
    @(negedge clk);
    checks++;
    if (ld_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_pulse: err=%b, want 0", ld_err);
    end
    issue_load(2'b10, 1'b0, 2'd0, 4'd9);
    repeat (3) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (ld_err !== 1'b0 || wb_en_out !== 1'b1 || wb_dest_out !== 4'd9 ||
        wb_value_out !== 32'hCAFE_F00D) begin
      failures++;
      $display("[TB] FAIL timeout_data_wins: err=%b en=%b dest=%0d val=%h, want 0 1 9 cafef00d",
               ld_err, wb_en_out, wb_dest_out, wb_value_out);
    end
  endtask

  task automatic test_ignored_rvalid();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    checks++;
    if (wb_en_out !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_rvalid: en=%b stall=%b, want 0 0", wb_en_out, stall);
    end
    issue_load(2'b11, 1'b0, 2'd0, 4'd4);
    mem_rvalid = 1'b0;
    checks++;
    if (wb_en_out !== 1'b0 || stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept_rvalid: en=%b stall=%b, want 0 1", wb_en_out, stall);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (wb_en_out !== 1'b1 || wb_value_out !== 32'h2222_2222) begin
      failures++;
      $display("[TB] FAIL late_rvalid: en=%b val=%h, want 1 22222222", wb_en_out, wb_value_out);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; mem_r_en = 1'b0; wb_en = 1'b1; wb_dest = 4'd1; alu_res = 32'hA5A5_0001;
    @(negedge clk);
    wb_en = 1'b0; wb_dest = 4'd2; alu_res = 32'h5A5A_0002;
    checks++;
    if (wb_en_out !== 1'b1 || wb_dest_out !== 4'd1 || wb_value_out !== 32'hA5A5_0001) begin
      failures++;
      $display("[TB] FAIL b2b_first: en=%b dest=%0d val=%h, want 1 1 a5a50001",
               wb_en_out, wb_dest_out, wb_value_out);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wb_en_out !== 1'b0 || wb_dest_out !== 4'd2 || wb_value_out !== 32'h5A5A_0002) begin
      failures++;
      $display("[TB] FAIL b2b_second: en=%b dest=%0d val=%h, want 0 2 5a5a0002",
               wb_en_out, wb_dest_out, wb_value_out);
    end
  endtask

  task automatic test_reset_abort();
    issue_load(2'b00, 1'b0, 2'd0, 4'd6);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || in_ready !== 1'b1 || wb_en_out !== 1'b0 || ld_err !== 1'b0 ||
        wb_value_out !== '0 || wb_dest_out !== '0) begin
      failures++;
      $display("[TB] FAIL abort_reset: stall=%b rdy=%b en=%b err=%b val=%h dest=%0d, want 0 1 0 0 0 0",
               stall, in_ready, wb_en_out, ld_err, wb_value_out, wb_dest_out);
    end
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_00AA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (wb_en_out !== 1'b0 || wb_value_out !== '0 || ld_err !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_late_rvalid: en=%b val=%h err=%b stall=%b, want 0 0 0 0",
               wb_en_out, wb_value_out, ld_err, stall);
    end
`ifdef WB_STATS_EN
    checks++;
    if (retire_cnt !== '0 || load_cnt !== '0 || timeout_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL abort_stats: r=%0d l=%0d t=%0d, want 0 0 0", retire_cnt, load_cnt, timeout_cnt);
    end
`endif
  endtask

`ifdef WB_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; mem_r_en = 1'b0; wb_en = 1'b1; wb_dest = 4'(i); alu_res = 32'(i);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (retire_cnt !== 2'd3 || load_cnt !== 2'd0 || timeout_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL stats_saturate: r=%0d l=%0d t=%0d, want 3 0 0", retire_cnt, load_cnt, timeout_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_byte_load();
    test_extract();
    test_timeout();
    test_ignored_rvalid();
    test_back_to_back();
    test_reset_abort();
`ifdef WB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
